wam_sch: RTL and testbench
==========================

# wam_sch

Mole scheduler and game sequencer for the whack-a-mole design. It consumes the per-level parameters (`age`, `rto`) from the hardness table and debounced hole touches. It decides when and where moles appear, ages them, scores hits, counts misses and ends the game. Its `cout0` pulse feeds the hardness controller's auto-harder input.

## Interface
Parameters:
- `STEP_CYC`, default 16: `clk_19` cycles per game step; legal range 2..65535.
- `MISS_MAX`, default 9: misses that end the game; legal range 1..15.

Ports:
- `clk_19`, in, 1: the single clock.
- `clr_n`, in, 1: reset; synchronous, active-low.
- `start`, in, 1: one-cycle pulse that begins a game.
- `age`, in, 4: mole lifetime in steps; a value of 0 is treated as 1.
- `rto`, in, 8: spawn threshold; only `rto[6:0]` is used.
- `hit`, in, 8: one-cycle debounced touch pulse per hole.
- `mole`, out, 8: mole present per hole.
- `score`, out, 8: two-digit BCD score, `{tens,ones}`.
- `miss`, out, 4: miss count.
- `cout0`, out, 1: one-cycle pulse on a ones-digit wrap.
- `over`, out, 1: high while in END.

## Operation
- **FSM states:** IDLE, RUN, END.
  - IDLE to RUN on `start`.
  - RUN to END when `miss` reaches `MISS_MAX`.
  - END to RUN on `start`.
  - `start` has no effect in RUN.
- **Entering RUN:**
  - `score`, `miss`, `mole` and all life counters are cleared.
  - Prescaler is set to 0.
- **IDLE and END:**
  - `mole` is held at 0.
  - `score` and `miss` hold their values.
  - `hit` is ignored.
  - Prescaler is idle.
- **Prescaler:** counts 0..STEP_CYC-1 in RUN only. `tick` is asserted when it equals STEP_CYC-1, then it wraps to 0.
- **LFSR:**
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Reset seed 8'hA5.
  - Advances every cycle in every state.
  - Each tick samples it as `r = lfsr[6:0]` and `h = lfsr[2:0]`.
- **Spawn (on tick, RUN):**
  - Condition: `r < rto[6:0]` and `mole[h]` is 0 at the start of the cycle.
  - Action: set `mole[h]` and load its life counter with `max(age,1)`.
  - `rto[6:0] = 0` means no spawns ever.
- **Aging (on tick):** every occupied hole not spawned this tick decrements its life counter. A hole whose life equals 1 expires: its `mole` clears and it counts as a miss.
- **Hit (any RUN cycle):**
  - Among set `hit[i]` with `mole[i]=1`, only the lowest index i is accepted.
  - An accepted hit clears `mole[i]` and adds 1 to `score`.
  - Other hits in that cycle are ignored, and their moles stay.
  - A hit on an empty hole is ignored.
- **Hit and expiry on the same hole in the same cycle:** the hit wins; it scores and is not a miss.
- **Miss arithmetic:** `miss` increases by the number of holes expiring this tick, saturating at `MISS_MAX`. Once `miss == MISS_MAX`, the next cycle is END.
- **Score arithmetic (BCD):**
  - Ones digit 9 becomes 0 with a carry into tens.
  - 99 becomes 00.
  - `cout0` pulses for one cycle on every ones-digit wrap, including 99 to 00.

## Timing
- **Registered outputs:** all outputs are registered and update on the rising edge of `clk_19`.
- **Reset values:** while `clr_n` is low at an edge, the block forces IDLE and:
  - `mole` = 0, `score` = 8'h00, `miss` = 0, `cout0` = 0, `over` = 0
  - lfsr = 8'hA5, prescaler = 0
  - Reset mid-game discards all state.
- **Start:** `start` at edge k puts the FSM in RUN from k+1. The first tick occurs at edge k+STEP_CYC.
- **Spawn latency:** on the tick edge; `mole` is visible after that edge. The mole stays visible for exactly `max(age,1)` ticks unless hit.
- **Hit latency:** a hit at edge n clears `mole` and updates `score` at edge n. `cout0` is high during cycle n+1 only.
- **Game end:** the edge where `miss` reaches `MISS_MAX` also updates `miss`. `over` rises and `mole` clears at the following edge.

## Test plan
1. **Reset values:** hold `clr_n` low 3 cycles, then release → all outputs 0, IDLE, no ticks, `hit` ignored.
2. **Spawn and expiry:** `start`, `rto`=127, `age`=2, no hits → a mole appears on the first tick at hole `lfsr[2:0]` and clears 2 ticks later; `miss` increments 1 per expiry; `over` rises after the 9th miss.
3. **Hit and score:** force moles, then pulse `hit` on an occupied hole, then on an empty one → `score` 00 to 01, mole cleared; the empty hit leaves `score` unchanged.
4. **Simultaneous hits:** `hit`=8'b0000_0110 with holes 1 and 2 occupied → only hole 1 clears, `score` +1.
5. **BCD wrap:** drive 10 accepted hits from 00 → `score`=8'h10 with one `cout0` pulse; continue to 99 then one more hit → 8'h00 with `cout0` pulsed.
6. **Hit beats expiry:** `age`=0 (treated as 1) and `rto`=0 → no spawns; then with `rto`=127, hit a mole on its expiry tick → scored, `miss` unchanged.

Source files
------------

// File: rtl/wam_sch.sv
// Whack-a-mole scheduler: step prescaler, LFSR spawn, mole aging, hit scoring, miss counting.
module wam_sch #(
  parameter int unsigned STEP_CYC = 16,
  parameter int unsigned MISS_MAX = 9
) (
  input  logic       clk_19,
  input  logic       clr_n,
  input  logic       start,
  input  logic [3:0] age,
  input  logic [7:0] rto,
  input  logic [7:0] hit,
  output logic [7:0] mole,
  output logic [7:0] score,
  output logic [3:0] miss,
  output logic       cout0,
  output logic       over
);

  localparam int unsigned PW = 16;
  localparam int unsigned NH = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [NH-1:0]       mole_q, mole_d;
  logic [NH-1:0][3:0]  life_q, life_d;
  logic [7:0]          score_q, score_d;
  logic [3:0]          miss_q, miss_d;
  logic                cout0_q, cout0_d;
  logic                over_q, over_d;

  logic                tick;
  logic [2:0]          h;
  logic [3:0]          age_eff;
  logic [NH-1:0]       cand;
  logic [NH-1:0]       hit_ok;
  logic [3:0]          n_exp;
  logic [4:0]          miss_sum;
  logic                unused_rto;

  assign unused_rto = rto[7];

  // Next-state: game sequencing, spawn/aging on tick, lowest-index hit acceptance, BCD score.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    mole_d   = mole_q;
    life_d   = life_q;
    score_d  = score_q;
    miss_d   = miss_q;
    cout0_d  = 1'b0;
    tick     = 1'b0;
    n_exp    = 4'd0;
    miss_sum = 5'd0;
    h        = lfsr_q[2:0];
    age_eff  = (age == 4'd0) ? 4'd1 : age;
    cand     = hit & mole_q;
    hit_ok   = 8'd0;

    case (state_q)
      S_IDLE, S_END: begin
        mole_d = 8'd0;
        if (start) begin
          state_d = S_RUN;
          pre_d   = '0;
          score_d = 8'd0;
          miss_d  = 4'd0;
          life_d  = '0;
        end
      end
      S_RUN: begin
        if (miss_q == 4'(MISS_MAX)) begin
          // Game finished: freeze everything except clearing the field.
          state_d = S_END;
          mole_d  = 8'd0;
        end else begin
          tick   = (pre_q == PW'(STEP_CYC - 1));
          pre_d  = tick ? '0 : pre_q + PW'(1);
          hit_ok = cand & (~cand + 8'd1);
          if (tick) begin
            for (int unsigned i = 0; i < NH; i++) begin
              if (mole_q[i]) begin
                if (life_q[i] == 4'd1) begin
                  mole_d[i] = 1'b0;
                  if (!hit_ok[i]) n_exp = n_exp + 4'd1;
                end else begin
                  life_d[i] = life_q[i] - 4'd1;
                end
              end
            end
            if ((lfsr_q[6:0] < rto[6:0]) && !mole_q[h]) begin
              mole_d[h] = 1'b1;
              life_d[h] = age_eff;
            end
          end
          if (|hit_ok) begin
            mole_d = mole_d & ~hit_ok;
            if (score_q[3:0] == 4'd9) begin
              score_d[3:0] = 4'd0;
              score_d[7:4] = (score_q[7:4] == 4'd9) ? 4'd0 : score_q[7:4] + 4'd1;
              cout0_d      = 1'b1;
            end else begin
              score_d[3:0] = score_q[3:0] + 4'd1;
            end
          end
          miss_sum = 5'(miss_q) + 5'(n_exp);
          miss_d   = (miss_sum >= 5'(MISS_MAX)) ? 4'(MISS_MAX) : miss_sum[3:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    over_d = (state_d == S_END);
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk_19) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      lfsr_q  <= 8'hA5;
      mole_q  <= 8'd0;
      life_q  <= '0;
      score_q <= 8'd0;
      miss_q  <= 4'd0;
      cout0_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      mole_q  <= mole_d;
      life_q  <= life_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      cout0_q <= cout0_d;
      over_q  <= over_d;
    end
  end

  assign mole  = mole_q;
  assign score = score_q;
  assign miss  = miss_q;
  assign cout0 = cout0_q;
  assign over  = over_q;

endmodule

// File: tb/tb_wam_sch.sv
// Randomized bench for wam_sch against a behavioural game model.
module tb_wam_sch;

  localparam int STEP = 4;
  localparam int MMAX = 9;

  logic       clk_19 = 1'b0;
  logic       clr_n;
  logic       start;
  logic [3:0] age;
  logic [7:0] rto;
  logic [7:0] hit;
  logic [7:0] mole;
  logic [7:0] score;
  logic [3:0] miss;
  logic       cout0;
  logic       over;

  wam_sch #(.STEP_CYC(STEP), .MISS_MAX(MMAX)) dut (
    .clk_19(clk_19), .clr_n(clr_n), .start(start), .age(age), .rto(rto),
    .hit(hit), .mole(mole), .score(score), .miss(miss), .cout0(cout0), .over(over)
  );

  always #5 clk_19 = ~clk_19;

  int nvec = 0;
  int nbad = 0;

  // Model: mode 0 idle, 1 playing, 2 game over; score kept as a decimal integer.
  int         m_mode;
  int         m_cyc;
  logic [7:0] m_lfsr;
  bit   [7:0] m_mole;
  int         m_life[8];
  int         m_score;
  int         m_miss;
  int         m_hits;
  bit         m_cout;
  bit         m_over;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1: feedback from stages 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'b1011_1000)};
  endfunction

  function automatic logic [7:0] to_bcd(input int s);
    return 8'(((s / 10) * 16) + (s % 10));
  endfunction

  task automatic model_edge();
    logic [7:0] nl;
    bit   [7:0] old;
    int         acc;
    int         expd;
    bit         tk;
    nl     = lfsr_next(m_lfsr);
    m_cout = 1'b0;
    if (!clr_n) begin
      m_mode = 0; m_cyc = 0; m_mole = '0; m_score = 0; m_miss = 0;
      m_over = 1'b0; m_lfsr = 8'hA5;
      return;
    end
    if (m_mode != 1) begin
      m_mole = '0;
      if (start) begin
        m_mode = 1; m_cyc = 0; m_score = 0; m_miss = 0; m_hits = 0;
        for (int i = 0; i < 8; i++) m_life[i] = 0;
      end
    end else if (m_miss == MMAX) begin
      m_mode = 2;
      m_mole = '0;
    end else begin
      tk    = (m_cyc == STEP - 1);
      m_cyc = tk ? 0 : m_cyc + 1;
      acc   = -1;
      for (int i = 0; i < 8; i++) if (acc < 0 && hit[i] && m_mole[i]) acc = i;
      old  = m_mole;
      expd = 0;
      if (tk) begin
        for (int i = 0; i < 8; i++) begin
          if (old[i]) begin
            m_life[i]--;
            if (m_life[i] == 0) begin
              m_mole[i] = 1'b0;
              if (i != acc) expd++;
            end
          end
        end
        if (int'(m_lfsr[6:0]) < int'(rto[6:0]) && !old[m_lfsr[2:0]]) begin
          m_mole[m_lfsr[2:0]] = 1'b1;
          m_life[m_lfsr[2:0]] = (age == 4'd0) ? 1 : int'(age);
        end
      end
      if (acc >= 0) begin
        m_mole[acc] = 1'b0;
        m_score     = (m_score + 1) % 100;
        m_hits++;
        m_cout      = (m_score % 10 == 0);
      end
      m_miss = (m_miss + expd > MMAX) ? MMAX : m_miss + expd;
    end
    m_over = (m_mode == 2);
    m_lfsr = nl;
  endtask

  task automatic cyc(input logic r, input logic s, input logic [7:0] h);
    @(negedge clk_19);
    clr_n = r; start = s; hit = h;
    @(posedge clk_19);
    model_edge();
    #1;
    chk("mole",  32'(mole),  32'(m_mole));
    chk("score", 32'(score), 32'(to_bcd(m_score)));
    chk("miss",  32'(miss),  32'(m_miss));
    chk("cout0", 32'(cout0), 32'(m_cout));
    chk("over",  32'(over),  32'(m_over));
  endtask

  function automatic logic [7:0] lowest_of(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 8'(1 << i);
    return 8'd0;
  endfunction

  initial begin
    int         n;
    int         nc;
    int         ev;
    int         mb;
    int         sb;
    logic [7:0] hv;

    clr_n = 1'b0; start = 1'b0; hit = 8'd0; age = 4'd2; rto = 8'd127;
    m_mode = 0; m_cyc = 0; m_lfsr = 8'hA5; m_mole = '0; m_score = 0;
    m_miss = 0; m_hits = 0; m_cout = 1'b0; m_over = 1'b0;
    for (int i = 0; i < 8; i++) m_life[i] = 0;

    // Reset, then idle with stray hits.
    repeat (3) cyc(1'b0, 1'b0, 8'($urandom));
    repeat (8) cyc(1'b1, 1'b0, 8'($urandom));

    // Spawn and expiry with no hits until the game ends.
    age = 4'd2; rto = 8'd127;
    cyc(1'b1, 1'b1, 8'd0);
    n = 0;
    while (!m_over && n < 2000) begin cyc(1'b1, 1'b0, 8'd0); n++; end
    chk("over_after_misses", 32'(over), 32'd1);
    chk("miss_at_end", 32'(miss), 32'(MMAX));
    repeat (4) cyc(1'b1, 1'b0, 8'($urandom));

    // Hits, empty hits, simultaneous hits and BCD wrap past 99.
    age = 4'd15; rto = 8'd127;
    cyc(1'b1, 1'b1, 8'd0);
    n = 0; nc = 0;
    while (m_hits < 105 && n < 4000) begin
      if (m_mole[2:1] == 2'b11) hv = 8'h06;
      else case ($urandom_range(0, 3))
        0: hv = lowest_of(m_mole);
        1: hv = m_mole | 8'($urandom);
        2: hv = ~m_mole & 8'($urandom);
        default: hv = 8'd0;
      endcase
      cyc(1'b1, ($urandom_range(0, 15) == 0), hv);
      if (cout0) nc++;
      n++;
    end
    chk("hits_reached", 32'(m_hits >= 105), 32'd1);
    chk("cout0_pulses", 32'(nc), 32'(m_hits / 10));

    // No spawns with rto 0, then hit moles on their expiry tick.
    age = 4'd0; rto = 8'd0;
    cyc(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'd0);
    repeat (40) cyc(1'b1, 1'b0, 8'($urandom));
    rto = 8'd127;
    n = 0; ev = 0;
    while (ev < 8 && n < 600) begin
      if (m_cyc == STEP - 1 && m_mole != 0) begin
        mb = m_miss; sb = m_score;
        cyc(1'b1, 1'b0, lowest_of(m_mole));
        chk("expiry_hit_miss", 32'(miss), 32'(mb));
        chk("expiry_hit_score", 32'(score), 32'(to_bcd((sb + 1) % 100)));
        ev++;
      end else begin
        cyc(1'b1, 1'b0, 8'd0);
      end
      n++;
    end
    chk("expiry_events", 32'(ev), 32'd8);

    // Free-running random play with restarts and mid-game resets.
    for (int k = 0; k < 800; k++) begin
      if (k % 50 == 0) begin
        age = 4'($urandom);
        rto = 8'($urandom);
      end
      case ($urandom_range(0, 3))
        0: hv = m_mole & 8'($urandom);
        1: hv = 8'($urandom);
        default: hv = 8'd0;
      endcase
      cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 39) == 0), hv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
